// File: rtl/serial_to_parallel_buf_if.sv
// serial_to_parallel_buf_if: serial input / parallel output handshake bundle.
// The in_last signal exists only when S2P_BUF_LAST_EN is defined.
interface serial_to_parallel_buf_if #(
    parameter int WIDTH  = 1,
    parameter int N_OUTS = 4
);
    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        in;
`ifdef S2P_BUF_LAST_EN
    logic                    in_last;
`endif
    logic                    out_valid;
    logic                    out_ready;
    logic [N_OUTS*WIDTH-1:0] out;
    logic [31:0]             out_count;
`ifdef S2P_BUF_LAST_EN
    modport master (output in_valid, in, in_last, out_ready, input in_ready, out_valid, out, out_count);
    modport slave  (input in_valid, in, in_last, out_ready, output in_ready, out_valid, out, out_count);
`else
    modport master (output in_valid, in, out_ready, input in_ready, out_valid, out, out_count);
    modport slave  (input in_valid, in, out_ready, output in_ready, out_valid, out, out_count);
`endif
endinterface

// File: rtl/serial_to_parallel_buf.sv
// serial_to_parallel_buf: ping-pong buffer packing N_OUTS serial elements into one word.
// Define S2P_BUF_LAST_EN to let in_last close a word early with a short count.
module serial_to_parallel_buf #(
    parameter int WIDTH  = 1,
    parameter int N_OUTS = 4
) (
    input logic                   clk,
    input logic                   rst,
    serial_to_parallel_buf_if.slave bus
);
    localparam int IW = N_OUTS > 1 ? $clog2(N_OUTS) : 1;
    logic [N_OUTS*WIDTH-1:0] data [2];
    logic [31:0]             cnt  [2];
    logic [1:0]              full;
    logic                    wp, rp;
    logic [IW-1:0]           idx;
    logic                    acc, con, close;
    always_comb begin
        acc = bus.in_valid && !full[wp];
        con = full[rp] && bus.out_ready;
`ifdef S2P_BUF_LAST_EN
        close = (idx == IW'(N_OUTS - 1)) || bus.in_last;
`else
        close = idx == IW'(N_OUTS - 1);
`endif
    end
    assign bus.in_ready  = !full[wp];
    assign bus.out_valid = full[rp];
    // a filling bank may sit at rp, so gate its partial contents off the output
    assign bus.out       = full[rp] ? data[rp] : '0;
    assign bus.out_count = full[rp] ? cnt[rp] : 32'd0;
    always_ff @(posedge clk) begin
        if (!rst) begin
            data[0] <= '0;
            data[1] <= '0;
            cnt[0]  <= '0;
            cnt[1]  <= '0;
            full    <= '0;
            wp      <= 1'b0;
            rp      <= 1'b0;
            idx     <= '0;
        end else begin
            // accept and consume always address different banks
            if (acc) begin
                data[wp][WIDTH*int'(idx) +: WIDTH] <= bus.in;
                if (close) begin
                    full[wp] <= 1'b1;
                    cnt[wp]  <= 32'(idx) + 32'd1;
                    wp       <= !wp;
                    idx      <= '0;
                end else begin
                    idx <= idx + 1'b1;
                end
            end
            if (con) begin
                full[rp] <= 1'b0;
                data[rp] <= '0;
                cnt[rp]  <= '0;
                rp       <= !rp;
            end
        end
    end
endmodule

// File: doc/serial_to_parallel_buf.md
SERIAL_TO_PARALLEL_BUF -- requirements
Module: serial_to_parallel_buf

Interface
REQ-001 SHALL have parameter WIDTH, default 1, bits per serial element.
REQ-002 SHALL have parameter N_OUTS, default 4, elements per parallel word (N_OUTS >= 1).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  input  1  reset; one clock; reset is synchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  serial element offered.
REQ-006 SHALL have port in_ready  output  1  element accepted when in_valid & in_ready.
REQ-007 SHALL have port in  input  WIDTH  serial element data.
REQ-008 SHALL have port in_last  input  1  accepted element closes current word early (S2P_BUF_LAST_EN only).
REQ-009 SHALL have port out_valid  output  1  parallel word available.
REQ-010 SHALL have port out_ready  input  1  word consumed when out_valid & out_ready.
REQ-011 SHALL have port out  output  N_OUTS*WIDTH  parallel word; element k at bits [WIDTH*k +: WIDTH].
REQ-012 SHALL have port out_count  output  32  number of valid elements in out (1..N_OUTS while out_valid, else 0).

Function
REQ-013 SHALL hold two banks (ping-pong), each N_OUTS*WIDTH data plus 32-bit element count and full flag.
REQ-014 SHALL fill the bank at write pointer wp in index order 0,1,..,N_OUTS-1 from an internal fill index.
REQ-015 SHALL mark bank wp full, toggle wp, and clear fill index when an accepted element lands at index N_OUTS-1.
REQ-016 SHALL present bank at read pointer rp on out/out_count; out_valid = full flag of bank rp (registered, no combinational path from in_valid).
REQ-017 SHALL assert out_valid the cycle after the accept that completes a word (latency 1).
REQ-018 SHALL, on out_valid & out_ready, clear full flag of bank rp, zero its data, and toggle rp.
REQ-019 SHALL drive in_ready = !full[wp]; in_ready low exactly when both banks full.
REQ-020 SHALL allow an input accept and an output consume in the same cycle; consume frees a bank visible to in_ready next cycle.
REQ-021 SHALL drive zero in elements at indices >= out_count of a presented word.
REQ-022 SHALL deliver words in completion order; no element lost, duplicated or reordered.
REQ-023 SHALL ignore in and in_last when in_valid & in_ready is false.
REQ-024 SHALL hold out and out_count stable while out_valid & !out_ready.
REQ-025 SHALL behave for N_OUTS = 1 as a two-entry WIDTH FIFO with out_count = 1.

Reset
REQ-026 SHALL, when rst = 0 at posedge clk, clear both full flags, wp, rp, fill index, counts, and bank data to 0.
REQ-027 SHALL output in_ready = 1, out_valid = 0, out = 0, out_count = 0 from the first cycle after reset.
REQ-028 SHALL discard any partial word and any unconsumed full words on reset mid-operation.
REQ-029 SHALL ignore in_valid and out_ready in a cycle where rst = 0.

Configuration
REQ-030 SHALL with S2P_BUF_LAST_EN defined: include in_last; an accepted element with in_last = 1 at index i marks bank full with count i+1, toggles wp, clears fill index.
REQ-031 SHALL with S2P_BUF_LAST_EN defined: in_last at index N_OUTS-1 behave identically to a normal word completion (count N_OUTS).
REQ-032 SHALL without S2P_BUF_LAST_EN: omit port in_last; every word contains exactly N_OUTS elements; out_count constant N_OUTS when out_valid.

Verification
REQ-033 SHALL cover: WIDTH=8,N_OUTS=4, out_ready=1, stream 1,2,3,4 on consecutive cycles -> out_valid one cycle after 4th accept, out=0x04030201, out_count=4.
REQ-034 SHALL cover: out_ready=0, stream 12 elements -> in_ready drops after 8th accept, 9th held; raise out_ready -> words 0x04030201 then 0x08070605, then 9..12 accepted.
REQ-035 SHALL cover: both banks full, single-cycle out_ready with in_valid high -> in_ready high next cycle, next element lands at index 0 of freed bank.
REQ-036 SHALL cover (S2P_BUF_LAST_EN): stream 5,6 with in_last on 6 -> out=0x00000605, out_count=2; following word starts at index 0.
REQ-037 SHALL cover: rst=0 after 2 elements accepted and one full word pending -> next cycle out_valid=0, in_ready=1, out=0; subsequent 4 elements form a clean word.
